// File: rtl/ledmatrix_scan.sv
// HUB75 32x32 scan controller: walks the 512x24 frame buffer, shifts BCM bit planes, drives clk/lat/oe/row.
// Optional build macro LEDMATRIX_GAMMA_EN maps each 4-bit channel through a gamma table before plane extraction.
module ledmatrix_scan #(
  parameter int CLK_DIV  = 4,
  parameter int BCM_UNIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [8:0]  rd_addr,
  input  logic [23:0] rd_data,
  output logic        led_r1,
  output logic        led_g1,
  output logic        led_b1,
  output logic        led_r2,
  output logic        led_g2,
  output logic        led_b2,
  output logic        led_clk,
  output logic        led_lat,
  output logic        led_oe_n,
  output logic [3:0]  led_row,
  output logic        frame_sync
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_SHOW} state_t;

  localparam logic [7:0]  PH_LAST = 8'(CLK_DIV - 1);
  localparam logic [13:0] BCM_U   = 14'(BCM_UNIT);

  state_t      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic [1:0]  plane_q, plane_d;
  logic [4:0]  pix_q, pix_d;
  logic [7:0]  ph_q, ph_d;
  logic        half_q, half_d;
  logic [13:0] show_q, show_d;
  logic [13:0] show_last;

  logic [8:0]  rd_addr_q;
  logic [5:0]  pins_q, pins_d;
  logic        led_clk_q, led_lat_q, led_oe_n_q, frame_sync_q;
  logic [3:0]  led_row_q;

  function automatic logic [3:0] gmap(input logic [3:0] v);
`ifdef LEDMATRIX_GAMMA_EN
    logic [3:0] r;
    case (v)
      4'd0, 4'd1, 4'd2:  r = 4'd0;
      4'd3, 4'd4, 4'd5:  r = 4'd1;
      4'd6, 4'd7:        r = 4'd2;
      4'd8:              r = 4'd3;
      4'd9:              r = 4'd4;
      4'd10:             r = 4'd5;
      4'd11:             r = 4'd6;
      4'd12:             r = 4'd8;
      4'd13:             r = 4'd10;
      4'd14:             r = 4'd12;
      default:           r = 4'd15;
    endcase
    return r;
`else
    return v;
`endif
  endfunction

  function automatic logic plane_bit(input logic [3:0] ch, input logic [1:0] p);
    logic [3:0] g;
    g = gmap(ch);
    return g[p];
  endfunction

  assign show_last = (BCM_U << plane_q) - 14'd1;

  always_comb begin
    for (int i = 0; i < 6; i++) pins_d[i] = plane_bit(rd_data[4*i +: 4], plane_q);
  end

  // Slot phase counts half panel-clock periods; half_q selects the high half.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    plane_d = plane_q;
    pix_d   = pix_q;
    ph_d    = ph_q;
    half_d  = half_q;
    show_d  = show_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_SHIFT;
        row_d   = 4'd0;
        plane_d = 2'd0;
        pix_d   = 5'd0;
        ph_d    = 8'd0;
        half_d  = 1'b0;
        show_d  = 14'd0;
      end
      S_SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d   = 8'd0;
          half_d = ~half_q;
          if (half_q) begin
            pix_d = pix_q + 5'd1;
            if (pix_q == 5'd31) state_d = S_LATCH;
          end
        end else begin
          ph_d = ph_q + 8'd1;
        end
      end
      S_LATCH: begin
        if (ph_q == PH_LAST) begin
          ph_d    = 8'd0;
          show_d  = 14'd0;
          state_d = S_SHOW;
        end else begin
          ph_d = ph_q + 8'd1;
        end
      end
      default: begin
        if (show_q == show_last) begin
          show_d  = 14'd0;
          state_d = S_SHIFT;
          plane_d = plane_q + 2'd1;
          if (plane_q == 2'd3) row_d = row_q + 4'd1;
        end else begin
          show_d = show_q + 14'd1;
        end
      end
    endcase
  end

  // Pin registers are loaded from next-state so every output is registered yet cycle-aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      row_q        <= 4'd0;
      plane_q      <= 2'd0;
      pix_q        <= 5'd0;
      ph_q         <= 8'd0;
      half_q       <= 1'b0;
      show_q       <= 14'd0;
      rd_addr_q    <= 9'd0;
      pins_q       <= 6'd0;
      led_clk_q    <= 1'b0;
      led_lat_q    <= 1'b0;
      led_oe_n_q   <= 1'b1;
      led_row_q    <= 4'd0;
      frame_sync_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      pix_q        <= pix_d;
      ph_q         <= ph_d;
      half_q       <= half_d;
      show_q       <= show_d;
      rd_addr_q    <= {~row_d, pix_d};
      led_clk_q    <= (state_d == S_SHIFT) && half_d;
      led_lat_q    <= (state_d == S_LATCH);
      led_oe_n_q   <= (state_d != S_SHOW);
      frame_sync_q <= (state_d == S_SHIFT) && (row_d == 4'd0) && (plane_d == 2'd0) &&
                      (pix_d == 5'd0) && (ph_d == 8'd0) && !half_d;
      if (state_d == S_LATCH && state_q != S_LATCH) led_row_q <= row_d;
      if (state_q == S_SHIFT && !half_q && ph_q == 8'd1) pins_q <= pins_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign led_r1     = pins_q[0];
  assign led_g1     = pins_q[1];
  assign led_b1     = pins_q[2];
  assign led_r2     = pins_q[3];
  assign led_g2     = pins_q[4];
  assign led_b2     = pins_q[5];
  assign led_clk    = led_clk_q;
  assign led_lat    = led_lat_q;
  assign led_oe_n   = led_oe_n_q;
  assign led_row    = led_row_q;
  assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_ledmatrix_scan.sv
// Scoreboard bench for ledmatrix_scan: expected pixel/address stream queued per scenario, popped on led_clk rises.
module tb_ledmatrix_scan;
  localparam int CLK_DIV  = 4;
  localparam int BCM_UNIT = 16;
  localparam int FRAME    = 20480;

  logic        clk, rst;
  logic [8:0]  rd_addr;
  logic [23:0] rd_data;
  logic        led_r1, led_g1, led_b1, led_r2, led_g2, led_b2;
  logic        led_clk, led_lat, led_oe_n, frame_sync;
  logic [3:0]  led_row;

  ledmatrix_scan #(.CLK_DIV(CLK_DIV), .BCM_UNIT(BCM_UNIT)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .led_r1(led_r1), .led_g1(led_g1), .led_b1(led_b1),
    .led_r2(led_r2), .led_g2(led_g2), .led_b2(led_b2),
    .led_clk(led_clk), .led_lat(led_lat), .led_oe_n(led_oe_n),
    .led_row(led_row), .frame_sync(frame_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] mem [512];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int n_chk = 0;
  int n_fail = 0;
  logic [14:0] sb_q [$];
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] gam(input logic [3:0] v);
`ifdef LEDMATRIX_GAMMA_EN
    logic [3:0] t [16] = '{4'd0,4'd0,4'd0,4'd1,4'd1,4'd1,4'd2,4'd2,
                           4'd3,4'd4,4'd5,4'd6,4'd8,4'd10,4'd12,4'd15};
    return t[v];
`else
    return v;
`endif
  endfunction

  task automatic sb_load(input int nrows);
    logic [8:0]  a;
    logic [23:0] d;
    logic [3:0]  c [6];
    logic [5:0]  e;
    for (int r = 0; r < nrows; r++)
      for (int p = 0; p < 4; p++)
        for (int col = 0; col < 32; col++) begin
          a = {4'(15 - r), 5'(col)};
          d = mem[a];
          for (int k = 0; k < 6; k++) begin
            c[k] = gam(d[4*k +: 4]);
            e[5-k] = c[k][p];
          end
          sb_q.push_back({a, e});
        end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_oe_n"}, int'(led_oe_n), 1);
    chk({tag, "_addr"}, int'(rd_addr), 0);
    chk({tag, "_row"}, int'(led_row), 0);
    chk({tag, "_pins"}, int'({led_r1, led_g1, led_b1, led_r2, led_g2, led_b2}), 0);
    chk({tag, "_clk_lat_fs"}, int'({led_clk, led_lat, frame_sync}), 0);
  endtask

  // Monitor: timing of lat/oe/clk, row select, frame period and scoreboard pops.
  int cyc, last_fs, rises, lat_len, oe_len, shows;
  bit have_fs;
  logic p_clk, p_lat, p_oe;
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      cyc = 0; last_fs = 0; rises = 0; lat_len = 0; oe_len = 0; shows = 0;
      have_fs = 1'b0; p_clk = 1'b0; p_lat = 1'b0; p_oe = 1'b1;
    end else begin
      logic [14:0] e;
      cyc++;
      if (frame_sync) begin
        if (have_fs) chk("fs_period", cyc - last_fs, FRAME);
        have_fs = 1'b1;
        last_fs = cyc;
      end
      if (led_clk && !p_clk) begin
        rises++;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("pixel", int'({rd_addr, led_r1, led_g1, led_b1, led_r2, led_g2, led_b2}), int'(e));
        end
      end
      if (led_lat && !p_lat) begin
        chk("rises_per_plane", rises, 32);
        rises = 0;
        lat_len = 0;
      end
      if (led_lat) lat_len++;
      if (!led_lat && p_lat) chk("lat_len", lat_len, CLK_DIV);
      if (!led_oe_n) oe_len++;
      if (!led_oe_n && p_oe) chk("led_row", int'(led_row), (shows / 4) % 16);
      if (led_oe_n && !p_oe) begin
        chk("oe_len", oe_len, BCM_UNIT << (shows % 4));
        shows++;
        oe_len = 0;
      end
      p_clk = led_clk; p_lat = led_lat; p_oe = led_oe_n;
    end
  end

  task automatic fill_pattern();
    for (int a = 0; a < 512; a++) begin
      logic [8:0] av;
      av = 9'(a);
      mem[a] = {av[3:0] ^ 4'h5, av[7:4], av[3:0] ^ 4'hA, ~av[3:0], {av[8:6], av[0]}, av[3:0]};
    end
  endtask

  task automatic release_and_check(input string tag);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_fs"}, int'(frame_sync), 1);
    chk({tag, "_addr"}, int'(rd_addr), 480);
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    fill_pattern();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");

    // Full frame with address-derived pattern
    sb_load(16);
    mon_en = 1'b1;
    release_and_check("start");
    repeat (FRAME + 300) @(negedge clk);
    chk("frame_sb_drain", sb_q.size(), 0);

    // Reset held 5 cycles mid-SHOW
    mon_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (!led_oe_n) found = 1'b1;
    end
    chk("show_found", int'(found), 1);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_reset_vals("show_rst");
    end
    release_and_check("show_rel");

    // Gamma: every R1 channel = 8
    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < 512; a++) mem[a] = 24'h000008;
    sb_q.delete();
    sb_load(1);
    @(negedge clk);
    mon_en = 1'b1;
    release_and_check("gamma_rel");
    repeat (1300) @(negedge clk);
    chk("gamma_sb_drain", sb_q.size(), 0);

    // One-cycle reset at pixel 17 of row 5
    mon_en = 1'b0;
    rst = 1'b1;
    fill_pattern();
    release_and_check("pre_r5");
    found = 1'b0;
    for (int i = 0; i < 12000 && !found; i++) begin
      @(negedge clk);
      if (rd_addr == 9'd337) found = 1'b1;
    end
    chk("r5p17_found", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("r5_rst_oe_n", int'(led_oe_n), 1);
    chk("r5_rst_clk", int'(led_clk), 0);
    chk("r5_rst_addr", int'(rd_addr), 0);
    release_and_check("r5_rel");
    @(negedge clk);
    chk("r5_rel_row", int'(led_row), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
